// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier in the refclk domain: pulses the PLL reset,
// waits for a stable synchronized lock, retries on timeout and reports hard failure.
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 24,
    parameter int LOCK_TIMEOUT_CYCLES = 24000,
    parameter int LOCK_STABLE_CYCLES  = 2400,
    parameter int MAX_RETRIES         = 7,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       reset_n,
    input  logic       extlock,
    input  logic       force_relock,
    output logic       pll_reset,
    output logic       pll_ready,
    output logic       fail,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        ST_RST_PULSE = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_MAX    = 4'(MAX_RETRIES);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retry_q, retry_d;
    logic [3:0]       retry_inc;
    logic [7:0]       loss_q, loss_d;
    logic [1:0]       sync_q, sync_d;
    logic             pll_reset_q, pll_reset_d;
    logic             pll_ready_q, pll_ready_d;
    logic             fail_q, fail_d;
    logic             lock_s;

    assign lock_s    = sync_q[1];
    assign retry_inc = retry_q + 4'd1;

    // State register; outputs are flopped alongside so none depend combinationally on inputs.
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RST_PULSE;
            cnt_q       <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            pll_ready_q <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            sync_q      <= sync_d;
            pll_reset_q <= pll_reset_d;
            pll_ready_q <= pll_ready_d;
            fail_q      <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        retry_d = retry_q;
        loss_d  = loss_q;
        sync_d  = {sync_q[0], extlock};
        if (force_relock) begin
            state_d = ST_RST_PULSE;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                ST_RST_PULSE: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    // A lock arriving on the timeout cycle is taken; no retry is charged.
                    if (lock_s) begin
                        state_d = ST_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        cnt_d   = '0;
                        state_d = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RST_PULSE;
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_LOCKED;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                ST_LOCKED: begin
                    cnt_d = '0;
                    if (!lock_s) begin
                        state_d = ST_RST_PULSE;
                        if (loss_q != 8'hFF) begin
                            loss_d = loss_q + 8'd1;
                        end
                    end
                end
                ST_FAIL: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_RST_PULSE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        pll_reset_d = 1'b0;
        pll_ready_d = 1'b0;
        fail_d      = 1'b0;
        case (state_d)
            ST_RST_PULSE: pll_reset_d = 1'b1;
            ST_LOCKED:    pll_ready_d = 1'b1;
            ST_FAIL: begin
                pll_reset_d = 1'b1;
                fail_d      = 1'b1;
            end
            default: ;
        endcase
    end

    assign pll_reset       = pll_reset_q;
    assign pll_ready       = pll_ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
// Directed bench for pll_lock_supervisor: every change of the output set is predicted together
// with its spacing in refclk cycles from the previous change, and checked by a separate monitor.
module tb_pll_lock_supervisor;

    logic       refclk = 1'b0;
    logic       reset_n;
    logic       extlock;
    logic       force_relock;
    logic       pll_reset;
    logic       pll_ready;
    logic       fail;
    logic [3:0] retry_count;
    logic [7:0] lock_loss_count;

    int vectors     = 0;
    int miscompares = 0;

    // Entry: {cycles since previous change[15:0], pll_reset, pll_ready, fail, retry[3:0], loss[7:0]}
    logic [30:0] exp_q[$];

    always #5 refclk = ~refclk;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(50),
        .LOCK_STABLE_CYCLES (10),
        .MAX_RETRIES        (3),
        .CNT_W              (16)
    ) dut (
        .refclk         (refclk),
        .reset_n        (reset_n),
        .extlock        (extlock),
        .force_relock   (force_relock),
        .pll_reset      (pll_reset),
        .pll_ready      (pll_ready),
        .fail           (fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    function automatic logic [30:0] ev(input int dt, input logic rst, input logic rdy,
                                       input logic fl, input logic [3:0] rc, input logic [7:0] llc);
        return {16'(dt), rst, rdy, fl, rc, llc};
    endfunction

    // Monitor: samples 2 ns after each edge; the time origin after a reset is the last edge
    // that still saw reset_n low (releases happen 1 ns after an edge).
    initial begin : monitor
        logic [14:0] snap;
        logic [14:0] prev;
        logic [30:0] e;
        logic        primed;
        int          cyc;
        int          last_evt;
        int          dt;
        primed   = 1'b0;
        prev     = '0;
        cyc      = 0;
        last_evt = 0;
        forever begin
            @(posedge refclk);
            cyc++;
            #2;
            snap = {pll_reset, pll_ready, fail, retry_count, lock_loss_count};
            if (primed && snap != prev) begin
                dt = cyc - last_evt;
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL event: outputs=%h after %0d cycles, but no change was expected", snap, dt);
                end else begin
                    e = exp_q.pop_front();
                    if (e[14:0] != snap || e[30:15] != 16'(dt)) begin
                        miscompares++;
                        $display("FAIL event: outputs=%h after %0d cycles, required outputs=%h after %0d cycles",
                                 snap, dt, e[14:0], e[30:15]);
                    end
                end
                last_evt = cyc;
            end
            if (!reset_n) last_evt = cyc + 1;
            prev   = snap;
            primed = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic wait_level(input int sel, input logic val, input string name);
        logic cur;
        cur = 1'bx;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            cur = (sel == 0) ? pll_reset : (sel == 1) ? pll_ready : fail;
            if (cur == val) return;
        end
        vectors++;
        miscompares++;
        $display("FAIL wait_%s: still %b after 1000 cycles, required %b", name, cur, val);
    endtask

    task automatic wait_rise(input int sel, input string name);
        wait_level(sel, 1'b0, name);
        wait_level(sel, 1'b1, name);
    endtask

    task automatic wait_fall(input int sel, input string name);
        wait_level(sel, 1'b1, name);
        wait_level(sel, 1'b0, name);
    endtask

    task automatic check_outs(input string name, input logic [14:0] want);
        logic [14:0] got;
        got = {pll_reset, pll_ready, fail, retry_count, lock_loss_count};
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: outputs=%h, required %h", name, got, want);
        end
    endtask

    // One lock-loss round trip from LOCKED: 1-cycle extlock drop, 4-cycle reset, 10-cycle stable window.
    task automatic loss_cycle(input logic [7:0] loss_after);
        exp_q.push_back(ev(5, 1'b1, 1'b0, 1'b0, 4'd0, loss_after));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, loss_after));
        exp_q.push_back(ev(11, 1'b0, 1'b1, 1'b0, 4'd0, loss_after));
        tick(2);
        extlock = 1'b0;
        tick(1);
        extlock = 1'b1;
        wait_rise(1, "ready_after_loss");
    endtask

    initial begin : driver
        reset_n      = 1'b0;
        extlock      = 1'b0;
        force_relock = 1'b0;
        tick(3);
        check_outs("reset_state", 15'h4000);

        // Nominal lock: extlock rises 20 cycles after pll_reset falls; ready 13 cycles later.
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
        exp_q.push_back(ev(33, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0));
        reset_n = 1'b1;
        wait_fall(0, "first_pulse");
        tick(20);
        extlock = 1'b1;
        wait_rise(1, "first_ready");

        // Repeated losses in LOCKED; the counter saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            loss_cycle((i > 255) ? 8'd255 : 8'(i));
        end

        // Glitch during STABLE: 5 high, 1 low, then high; ready only after 10 clean cycles.
        exp_q.push_back(ev(5, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(29, 1'b0, 1'b1, 1'b0, 4'd0, 8'd255));
        tick(2);
        extlock = 1'b0;
        wait_fall(0, "glitch_pulse");
        tick(10);
        extlock = 1'b1;
        tick(5);
        extlock = 1'b0;
        tick(1);
        extlock = 1'b1;
        wait_rise(1, "glitch_ready");

        // force_relock on the timeout cycle wins, then three real timeouts end in FAIL.
        exp_q.push_back(ev(5, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(50, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(50, 1'b1, 1'b0, 1'b0, 4'd1, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd1, 8'd255));
        exp_q.push_back(ev(50, 1'b1, 1'b0, 1'b0, 4'd2, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd2, 8'd255));
        exp_q.push_back(ev(50, 1'b1, 1'b0, 1'b1, 4'd3, 8'd255));
        tick(2);
        extlock = 1'b0;
        wait_fall(0, "loss_before_timeout");
        tick(49);
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        wait_rise(2, "fail");

        // Recovery from FAIL with extlock already high.
        exp_q.push_back(ev(9, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(11, 1'b0, 1'b1, 1'b0, 4'd0, 8'd255));
        tick(5);
        extlock = 1'b1;
        tick(3);
        force_relock = 1'b1;
        tick(1);
        force_relock = 1'b0;
        wait_rise(1, "ready_after_fail");

        // reset_n asserted mid-STABLE: outputs return to reset values at once, then relock.
        exp_q.push_back(ev(5, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd255));
        exp_q.push_back(ev(5, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
        exp_q.push_back(ev(4, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
        exp_q.push_back(ev(11, 1'b0, 1'b1, 1'b0, 4'd0, 8'd0));
        tick(2);
        extlock = 1'b0;
        tick(1);
        extlock = 1'b1;
        wait_fall(0, "pulse_before_reset");
        tick(5);
        reset_n = 1'b0;
        #1;
        check_outs("async_reset", 15'h4000);
        tick(2);
        reset_n = 1'b1;
        wait_rise(1, "ready_after_reset");

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick(1);
        tick(5);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected changes never seen, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences the reset of the board PLL and qualifies its lock output; runs in the 24 MHz refclk domain.
- Sits directly around the pll instance. It drives the PLL `reset` input and consumes the PLL `extlock` output.
- Produces one clean `pll_ready` qualifier. The DVI pixel/serial domain reset logic uses it to release their resets.
- Retries lock with a bounded count, reports hard failure, and counts lock losses.

Parameters:
- RST_PULSE_CYCLES, 24: refclk cycles `pll_reset` is held high per attempt (1 us).
- LOCK_TIMEOUT_CYCLES, 24000: maximum cycles to wait for lock after `pll_reset` is released (1 ms).
- LOCK_STABLE_CYCLES, 2400: cycles the synchronized lock must stay continuously high before `pll_ready` is asserted (100 us).
- MAX_RETRIES, 7: failed lock attempts allowed before entering FAIL (1..15).
- CNT_W, 16: width of the shared cycle counter. It must hold max(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES).

Ports:
- refclk  input  1  24 MHz board clock, sole clock
- reset_n  input  1  asynchronous active-low reset, released synchronously by the system
- extlock  input  1  PLL lock, asynchronous to refclk
- force_relock  input  1  single-cycle request to restart the sequence
- pll_reset  output  1  active-high reset to the PLL
- pll_ready  output  1  PLL locked and stable
- fail  output  1  retries exhausted
- retry_count  output  4  failed attempts in the current sequence
- lock_loss_count  output  8  saturating count of lock losses seen in LOCKED

Behaviour:
- Reset values (reset_n low):
  - `pll_reset`=1, `pll_ready`=0, `fail`=0, `retry_count`=0, `lock_loss_count`=0.
  - State=RST_PULSE, counter=0, synchronizer flops=0.
- Synchronizer: `extlock` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`, so there are 2 cycles of input latency.
- All outputs are registered and decoded from the state register. No combinational paths run from inputs to outputs.
- States and transitions:
  - RST_PULSE: `pll_reset`=1. Counter counts 0..RST_PULSE_CYCLES-1, then go to WAIT_LOCK with counter cleared. `pll_reset` is high for exactly RST_PULSE_CYCLES cycles per entry.
  - WAIT_LOCK: `pll_reset`=0.
    - If `lock_s`=1, go to STABLE with counter cleared.
    - Else, when the counter reaches LOCK_TIMEOUT_CYCLES-1, increment `retry_count`. If the new value equals MAX_RETRIES, go to FAIL; else go to RST_PULSE.
    - If `lock_s` rises in the same cycle the timeout expires, lock wins and no retry is counted.
  - STABLE: `pll_reset`=0.
    - If `lock_s` drops, go to WAIT_LOCK. The counter is cleared and the timeout window restarts. The drop is not counted as a retry.
    - When the counter reaches LOCK_STABLE_CYCLES-1 with `lock_s` still high, go to LOCKED.
  - LOCKED: `pll_ready`=1.
    - `retry_count` is cleared on entry.
    - If `lock_s` drops, go to RST_PULSE. `pll_ready` deasserts on that same transition edge. `lock_loss_count` increments and saturates at 255.
  - FAIL: `pll_reset`=1 (held), `fail`=1, `pll_ready`=0. The block stays here until `force_relock` or `reset_n`.
- `force_relock`:
  - Sampled in every state and takes priority over all other transitions in the same cycle.
  - Goes to RST_PULSE with counter cleared, `retry_count` cleared and `fail` cleared.
  - `lock_loss_count` is not affected.
  - A relock forced from LOCKED does not count as a lock loss.
- `pll_ready` is 1 only in LOCKED. It can never be 1 while `pll_reset` is 1.
- Counter: CNT_W bits, cleared on every state change and never wraps. The compare uses ==, so no overflow is reachable if CNT_W is sized correctly.
- `reset_n` asserted mid-sequence:
  - All state returns to reset values immediately (asynchronously).
  - `pll_reset` goes high with no glitch to 0.

Test Plan (bench params: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=50, LOCK_STABLE_CYCLES=10, MAX_RETRIES=3):
1. Nominal lock: release reset_n, raise extlock 20 cycles after `pll_reset` falls -> `pll_reset` high exactly 4 cycles; `pll_ready` rises 2+10 cycles (±1 for entry cycle) after extlock; `retry_count`=0.
2. Timeout retries: hold extlock=0 -> three 4-cycle `pll_reset` pulses spaced by 50 cycles; `retry_count` steps 1,2,3; `fail`=1 with `pll_reset` held high after the third timeout.
3. Lock glitch during STABLE: extlock high 5 cycles, low 1, high again -> no `pll_ready` until 10 clean cycles after the re-lock; `retry_count` unchanged; no `pll_reset` pulse.
4. Loss in LOCKED: drop extlock after `pll_ready`=1 -> `pll_ready` falls 3 cycles later, `lock_loss_count`=1, new 4-cycle `pll_reset` pulse; repeat 300 times -> count saturates at 255.
5. Recover from FAIL: in FAIL, pulse `force_relock` with extlock=1 -> `fail`=0, `retry_count`=0, 4-cycle pulse, `pll_ready`=1 after the stable window.
6. Priority/corner: pulse `force_relock` in the same cycle as the WAIT_LOCK timeout -> RST_PULSE entered, `retry_count`=0; assert reset_n mid-STABLE -> all outputs at reset values within the same cycle.
